// File: rtl/chip8_kb_pkg.sv
// Shared constants and types for the CHIP-8 hex keypad scanner.
package chip8_kb_pkg;

   localparam int EVT_W          = 8;
   localparam int EVT_PRESS_BIT  = 7;
   localparam int EVT_FIFO_DEPTH = 4;

   // Physical [row][col] position to CHIP-8 key number (COSMAC VIP layout).
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hC},
      '{4'h4, 4'h5, 4'h6, 4'hD},
      '{4'h7, 4'h8, 4'h9, 4'hE},
      '{4'hA, 4'h0, 4'hB, 4'hF}
   };

   typedef enum logic [1:0] {
      ST_DRIVE   = 2'd0,
      ST_SAMPLE  = 2'd1,
      ST_COMPARE = 2'd2,
      ST_EMIT    = 2'd3
   } kb_state_t;

   // Event byte in the legacy get_key format: {pressed, 3'b0, key}.
   function automatic logic [EVT_W-1:0] evt_pack(input logic pressed, input logic [3:0] key);
      logic [EVT_W-1:0] e;
      e                = '0;
      e[EVT_PRESS_BIT] = pressed;
      e[3:0]           = key;
      return e;
   endfunction

endpackage

// File: rtl/chip8_evt_fifo.sv
// Four-entry first-word-fall-through event queue with a sticky drop flag.
module chip8_evt_fifo
   import chip8_kb_pkg::*;
(
   input  logic             clk_in,
   input  logic             rst_n_in,
   input  logic             push,
   input  logic [EVT_W-1:0] push_data,
   input  logic             evt_ready,
   output logic             evt_valid,
   output logic [EVT_W-1:0] evt_data,
   output logic             overflow_out
);

   localparam int PW = $clog2(EVT_FIFO_DEPTH);

   logic [EVT_W-1:0] mem [EVT_FIFO_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [PW:0]      count;
   logic             full, pop, push_ok;

   assign full      = (count == (PW+1)'(EVT_FIFO_DEPTH));
   assign evt_valid = (count != '0);
   assign pop       = evt_valid && evt_ready;
   // A pop in the same cycle frees the slot, so a push into a full queue still lands.
   assign push_ok   = push && (!full || pop);
   // Empty queue presents zero so the head never shows stale data.
   assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

   // Storage; contents are don't-care while the slot is not counted.
   always_ff @(posedge clk_in) begin
      if (push_ok) mem[wr_ptr] <= push_data;
   end

   // Pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_out <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)     rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
         if (push && !push_ok) overflow_out <= 1'b1;
      end
   end

endmodule

// File: rtl/chip8_keypad_scanner.sv
// 4x4 hex keypad matrix scanner with whole-frame debounce and a press/release event queue.
module chip8_keypad_scanner
   import chip8_kb_pkg::*;
#(
   parameter int SETTLE_CYCLES  = 16,
   parameter int DEBOUNCE_SCANS = 4
) (
   input  logic             clk_in,
   input  logic             rst_n_in,
   output logic [3:0]       col_out,
   input  logic [3:0]       row_in,
   output logic [15:0]      keys_out,
   output logic             evt_valid,
   output logic [EVT_W-1:0] evt_data,
   input  logic             evt_ready,
   output logic             overflow_out
);

   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [3:0]    STAB_MAX    = 4'(DEBOUNCE_SCANS);

   if (SETTLE_CYCLES < 3) begin : g_bad_settle
      $error("SETTLE_CYCLES must cover the two-flop row synchronizer");
   end
   if (DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15) begin : g_bad_debounce
      $error("DEBOUNCE_SCANS must be within 1..15");
   end

   kb_state_t        state;
   logic [1:0]       col_idx;
   logic [CW-1:0]    settle_cnt;
   logic [3:0]       emit_k;
   logic [3:0]       row_meta, row_sync;
   logic [15:0]      raw, prev_raw, diff;
   logic [3:0]       stab, stab_nxt;
   logic             commit;
   logic             push;
   logic [EVT_W-1:0] push_data;

   // Two-flop synchronizer on the asynchronous row sense lines.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         row_meta <= '0;
         row_sync <= '0;
      end else begin
         row_meta <= row_in;
         row_sync <= row_meta;
      end
   end

   // Column drive; gated by reset so the matrix is idle while reset is held.
   always_comb begin
      col_out = 4'hF;
      if (rst_n_in && (state == ST_DRIVE || state == ST_SAMPLE)) col_out[col_idx] = 1'b0;
   end

   // Debounce counter update and commit decision for the frame just completed.
   always_comb begin
      if (raw == prev_raw) stab_nxt = (stab >= STAB_MAX) ? STAB_MAX : stab + 4'd1;
      else                 stab_nxt = 4'd1;
      commit = (stab_nxt == STAB_MAX) && (raw != keys_out);
   end

   // Scan / debounce / emit sequencer.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state      <= ST_DRIVE;
         col_idx    <= '0;
         settle_cnt <= '0;
         emit_k     <= '0;
         raw        <= '0;
         prev_raw   <= '0;
         diff       <= '0;
         stab       <= '0;
         keys_out   <= '0;
      end else begin
         case (state)
            ST_DRIVE: begin
               if (settle_cnt == SETTLE_LAST) begin
                  settle_cnt <= '0;
                  state      <= ST_SAMPLE;
               end else begin
                  settle_cnt <= settle_cnt + 1'b1;
               end
            end
            ST_SAMPLE: begin
               // Rows are active-low; store 1 = pressed at the mapped key position.
               for (int r = 0; r < 4; r++) raw[KEYMAP[r][col_idx]] <= ~row_sync[r];
               if (col_idx == 2'd3) begin
                  state <= ST_COMPARE;
               end else begin
                  col_idx <= col_idx + 1'b1;
                  state   <= ST_DRIVE;
               end
            end
            ST_COMPARE: begin
               stab     <= stab_nxt;
               prev_raw <= raw;
               col_idx  <= '0;
               if (commit) begin
                  diff     <= raw ^ keys_out;
                  keys_out <= raw;
                  emit_k   <= '0;
                  state    <= ST_EMIT;
               end else begin
                  state <= ST_DRIVE;
               end
            end
            ST_EMIT: begin
               emit_k <= emit_k + 1'b1;
               if (emit_k == 4'hF) state <= ST_DRIVE;
            end
            default: state <= ST_DRIVE;
         endcase
      end
   end

   // One event per changed key, ascending key order; keys_out already holds the new level.
   assign push      = (state == ST_EMIT) && diff[emit_k];
   assign push_data = evt_pack(keys_out[emit_k], emit_k);

   chip8_evt_fifo u_fifo (
      .clk_in       (clk_in),
      .rst_n_in     (rst_n_in),
      .push         (push),
      .push_data    (push_data),
      .evt_ready    (evt_ready),
      .evt_valid    (evt_valid),
      .evt_data     (evt_data),
      .overflow_out (overflow_out)
   );

endmodule
